// File: rtl/pixel_stream_tx_pkg.sv
// rtl/pixel_stream_tx_pkg.sv - shared widths, FSM encoding and helpers for the pixel transmitter
package pixel_stream_tx_pkg;

  localparam int PIXEL_SIZE = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HSYNC  = 2'd2,
    ST_VSYNC  = 2'd3
  } tx_state_t;

  // Counter width that stays legal for single-entry dimensions.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - upstream pixel valid/ready handshake
interface pixel_stream_tx_if;
  import pixel_stream_tx_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [PIXEL_SIZE-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with async active-low reset
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged before any same-cycle pop, so a full FIFO never accepts.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - buffers upstream pixels and emits them with en/hsync/vsync framing
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int FRAME_WIDTH  = 550,
  parameter int FRAME_HEIGHT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  pixel_stream_tx_if.slave      pix_in,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  underrun
);

  localparam int XW = cnt_width(FRAME_WIDTH);
  localparam int YW = cnt_width(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  tx_state_t             state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  en_d, hsync_d, vsync_d, underrun_d;
  logic [PIXEL_SIZE-1:0] data_d;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [PIXEL_SIZE-1:0] fifo_rd_data;

  assign pix_in.in_ready = !fifo_full;

  pixel_fifo #(
    .WIDTH (PIXEL_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (pix_in.in_valid),
    .wr_data (pix_in.in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      en       <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      data     <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      en       <= en_d;
      hsync    <= hsync_d;
      vsync    <= vsync_d;
      data     <= data_d;
      underrun <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    en_d       = 1'b0;
    hsync_d    = 1'b0;
    vsync_d    = 1'b0;
    data_d     = data;
    underrun_d = underrun;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_ACTIVE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          en_d     = 1'b1;
          data_d   = fifo_rd_data;
          // Last pixel of the row leaves x parked; the sync state clears it.
          if (x_q == X_LAST) begin
            state_d = (y_q == Y_LAST) ? ST_VSYNC : ST_HSYNC;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_HSYNC: begin
        hsync_d = 1'b1;
        x_d     = '0;
        y_d     = y_q + 1'b1;
        state_d = ST_ACTIVE;
      end
      ST_VSYNC: begin
        vsync_d = 1'b1;
        x_d     = '0;
        y_d     = '0;
        state_d = run ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - self-checking bench for pixel_stream_tx
module tb_pixel_stream_tx;
  import pixel_stream_tx_pkg::*;

  logic clk, reset_n, run, run_w;
  logic en, hsync, vsync, underrun;
  logic [PIXEL_SIZE-1:0] data;
  logic en_w, hsync_w, vsync_w, underrun_w;
  logic [PIXEL_SIZE-1:0] data_w;
  int checks = 0;
  int errors = 0;

  pixel_stream_tx_if if_a ();
  pixel_stream_tx_if if_b ();

  pixel_stream_tx #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pix_in(if_a),
    .en(en), .hsync(hsync), .vsync(vsync), .data(data), .underrun(underrun)
  );

  pixel_stream_tx #(.FRAME_WIDTH(550), .FRAME_HEIGHT(1), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .run(run_w), .pix_in(if_b),
    .en(en_w), .hsync(hsync_w), .vsync(vsync_w), .data(data_w), .underrun(underrun_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        run;
    logic        vld;
    logic [23:0] din;
    logic        en;
    logic        hs;
    logic        vs;
    logic [23:0] dout;
    logic        rdy;
    logic        urun;
  } vec_t;

  vec_t tbl [0:22];

  function automatic vec_t mk(input bit r, input bit vl, input int d, input bit e,
                              input bit h, input bit vs, input int q, input bit rd, input bit u);
    vec_t t;
    t.run = r; t.vld = vl; t.din = d[23:0]; t.en = e; t.hs = h; t.vs = vs;
    t.dout = q[23:0]; t.rdy = rd; t.urun = u;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    run = t.run;
    if_a.in_valid = t.vld;
    if_a.in_data  = t.din;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({en, hsync, vsync, data, if_a.in_ready, underrun} !== {t.en, t.hs, t.vs, t.dout, t.rdy, t.urun}) begin
      errors++;
      $display("FAIL %s: got en=%b hs=%b vs=%b data=%h rdy=%b urun=%b required en=%b hs=%b vs=%b data=%h rdy=%b urun=%b",
               nm, en, hsync, vsync, data, if_a.in_ready, underrun,
               t.en, t.hs, t.vs, t.dout, t.rdy, t.urun);
    end
  endtask

  logic [23:0] exp_q [$];
  int          occ, npix, due;
  bit          started, acc, vld, drain;
  logic [23:0] last_px, exp_px;
  logic [31:0] dat;
  int          wcnt, wexp, en_cnt, nvs, hs_cnt, last_vs;
  bit          wacc;

  initial begin
    reset_n = 1'b0; run = 1'b0; run_w = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;

    // Preload four pixels with run low, then two frames of 4x2 and an underrun.
    tbl[0]  = mk(0,1, 1, 0,0,0, 0,1,0);
    tbl[1]  = mk(0,1, 2, 0,0,0, 0,1,0);
    tbl[2]  = mk(0,1, 3, 0,0,0, 0,1,0);
    tbl[3]  = mk(0,1, 4, 0,0,0, 0,0,0);
    tbl[4]  = mk(0,1, 5, 0,0,0, 0,0,0);
    tbl[5]  = mk(1,1, 5, 0,0,0, 0,0,0);
    tbl[6]  = mk(1,1, 5, 1,0,0, 1,1,0);
    tbl[7]  = mk(1,1, 5, 1,0,0, 2,1,0);
    tbl[8]  = mk(1,1, 6, 1,0,0, 3,1,0);
    tbl[9]  = mk(1,1, 7, 1,0,0, 4,1,0);
    tbl[10] = mk(1,1, 8, 0,1,0, 4,0,0);
    tbl[11] = mk(1,1, 9, 1,0,0, 5,1,0);
    tbl[12] = mk(1,1, 9, 1,0,0, 6,1,0);
    tbl[13] = mk(1,1,10, 1,0,0, 7,1,0);
    tbl[14] = mk(1,1,11, 1,0,0, 8,1,0);
    tbl[15] = mk(1,1,12, 0,0,1, 8,0,0);
    tbl[16] = mk(1,1,13, 1,0,0, 9,1,0);
    tbl[17] = mk(1,0, 0, 1,0,0,10,1,0);
    tbl[18] = mk(1,0, 0, 1,0,0,11,1,0);
    tbl[19] = mk(1,0, 0, 1,0,0,12,1,0);
    tbl[20] = mk(1,0, 0, 0,1,0,12,1,0);
    tbl[21] = mk(1,0, 0, 0,0,0,12,1,1);
    tbl[22] = mk(1,0, 0, 0,0,0,12,1,1);

    repeat (2) @(negedge clk);
    chk("reset_state", {en, hsync, vsync, underrun, data}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Three-cycle in_valid gap mid-row, then run drops at frame end.
    step(mk(1,1,13, 0,0,0,12,1,1), "gap_c0");
    step(mk(1,1,14, 1,0,0,13,1,1), "gap_c1");
    step(mk(1,0, 0, 1,0,0,14,1,1), "gap_c2");
    step(mk(1,0, 0, 0,0,0,14,1,1), "gap_c3");
    step(mk(1,0, 0, 0,0,0,14,1,1), "gap_c4");
    step(mk(1,1,15, 0,0,0,14,1,1), "gap_c5");
    step(mk(1,1,16, 1,0,0,15,1,1), "gap_c6");
    step(mk(1,0, 0, 1,0,0,16,1,1), "gap_c7");
    step(mk(0,0, 0, 0,0,1,16,1,1), "gap_c8");
    step(mk(0,0, 0, 0,0,0,16,1,1), "gap_c9");

    // run deasserted after the 2nd pixel of a 4x2 frame.
    step(mk(0,1,21, 0,0,0,16,1,1), "stop_r0");
    step(mk(0,1,22, 0,0,0,16,1,1), "stop_r1");
    step(mk(0,1,23, 0,0,0,16,1,1), "stop_r2");
    step(mk(0,1,24, 0,0,0,16,0,1), "stop_r3");
    step(mk(1,1,25, 0,0,0,16,0,1), "stop_r4");
    step(mk(1,1,25, 1,0,0,21,1,1), "stop_r5");
    step(mk(0,1,25, 1,0,0,22,1,1), "stop_r6");
    step(mk(0,1,26, 1,0,0,23,1,1), "stop_r7");
    step(mk(0,1,27, 1,0,0,24,1,1), "stop_r8");
    step(mk(0,1,28, 0,1,0,24,0,1), "stop_r9");
    step(mk(0,0, 0, 1,0,0,25,1,1), "stop_r10");
    step(mk(0,0, 0, 1,0,0,26,1,1), "stop_r11");
    step(mk(0,0, 0, 1,0,0,27,1,1), "stop_r12");
    step(mk(0,0, 0, 1,0,0,28,1,1), "stop_r13");
    step(mk(0,0, 0, 0,0,1,28,1,1), "stop_r14");
    step(mk(0,0, 0, 0,0,0,28,1,1), "stop_r15");
    step(mk(0,0, 0, 0,0,0,28,1,1), "stop_r16");

    // Async reset mid-row flushes the FIFO and restarts at x=0, y=0.
    step(mk(1,1,31, 0,0,0,28,1,1), "rst_p0");
    step(mk(1,1,32, 1,0,0,31,1,1), "rst_p1");
    if_a.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {en, hsync, vsync, underrun, data}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(mk(1,1,41, 0,0,0, 0,1,0), "rst_t0");
    step(mk(1,1,42, 1,0,0,41,1,0), "rst_t1");
    step(mk(1,1,43, 1,0,0,42,1,0), "rst_t2");
    step(mk(1,1,44, 1,0,0,43,1,0), "rst_t3");
    step(mk(1,0, 0, 1,0,0,44,1,0), "rst_t4");
    step(mk(1,0, 0, 0,1,0,44,1,0), "rst_t5");
    step(mk(1,0, 0, 0,0,0,44,1,1), "rst_t6");

    // Randomized traffic against a stream-level model.
    @(negedge clk);
    reset_n = 1'b0; run = 1'b0; if_a.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    occ = 0; npix = 0; due = 0; started = 0; last_px = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 700; cyc++) begin
      drain = (cyc >= 500);
      if (drain && exp_q.size() == 0 && occ == 0 && due == 0) break;
      run = 1'b1;
      vld = !drain && ($urandom_range(0, 3) != 0);
      dat = $urandom;
      if_a.in_valid = vld;
      if_a.in_data  = dat[23:0];
      acc = vld && if_a.in_ready;
      @(posedge clk);
      @(negedge clk);
      chk("rand_no_overlap", {31'b0, (hsync && vsync) || (en && (hsync || vsync))}, 32'h0);
      if (due != 0) begin
        chk("rand_marker", {29'b0, en, hsync, vsync}, {29'b0, 1'b0, due == 1, due == 2});
        due = 0;
      end else begin
        chk("rand_no_sync", {30'b0, hsync, vsync}, 32'h0);
        if (en) begin
          if (exp_q.size() > 0) exp_px = exp_q.pop_front();
          else exp_px = 'x;
          chk("rand_data", {8'h0, data}, {8'h0, exp_px});
          last_px = exp_px;
          started = 1'b1;
          npix++;
          if (npix % 4 == 0) due = (npix % 8 == 0) ? 2 : 1;
        end else begin
          chk("rand_hold", {8'h0, data}, {8'h0, last_px});
          if (started) chk("rand_underrun", {31'b0, underrun}, 32'h1);
        end
      end
      occ = occ + int'(acc) - int'(en);
      chk("rand_ready", {31'b0, if_a.in_ready}, {31'b0, occ < 4});
      if (acc) exp_q.push_back(dat[23:0]);
    end
    chk("rand_drained", exp_q.size() + occ + due, 0);
    chk("rand_progress", {31'b0, npix > 200}, 32'h1);
    run = 1'b0;

    // 550x1 frame: vsync every 551 cycles, never hsync.
    run_w = 1'b1; if_b.in_valid = 1'b1;
    wcnt = 0; wexp = 0; en_cnt = 0; nvs = 0; hs_cnt = 0; last_vs = -1;
    for (int cyc = 0; cyc < 2400 && nvs < 4; cyc++) begin
      if_b.in_data = wcnt[23:0];
      wacc = if_b.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (wacc) wcnt++;
      if (hsync_w) hs_cnt++;
      if (en_w) begin
        chk("wide_data", {8'h0, data_w}, {8'h0, wexp[23:0]});
        wexp++;
        en_cnt++;
      end
      if (vsync_w) begin
        chk("wide_row_pixels", en_cnt, 550);
        if (last_vs >= 0) chk("wide_vsync_period", cyc - last_vs, 551);
        last_vs = cyc;
        en_cnt = 0;
        nvs++;
      end
    end
    chk("wide_vsync_count", nvs, 4);
    chk("wide_no_hsync", hs_cnt, 0);
    chk("wide_no_underrun", {31'b0, underrun_w}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
